irq_arbiter: RTL and testbench

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_pkg.sv | 34 +++
 rtl/irq_prio_sel.sv | 29 ++
 rtl/irq_arbiter.sv | 164 ++++++++++++++++
 tb/tb_irq_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and types for the APB interrupt arbiter.
package irq_pkg;

    localparam int PRIO_W  = 3;   // priority field width per source
    localparam int MAX_SRC = 8;   // largest supported source count
    localparam int ID_W    = 3;   // enough bits to name any source

    // Word offsets decoded from paddr[4:2]
    localparam logic [2:0] OFF_PENDING = 3'd0;
    localparam logic [2:0] OFF_ENABLE  = 3'd1;
    localparam logic [2:0] OFF_PRIO    = 3'd2;
    localparam logic [2:0] OFF_THRESH  = 3'd3;
    localparam logic [2:0] OFF_CLAIM   = 3'd4;

    // One decoded APB access, valid in the cycle it is accepted
    typedef struct packed {
        logic       fire;
        logic       wr;
        logic       err;
        logic [2:0] off;
    } apb_acc_t;

    // Replace only the byte lanes whose strobe is set
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  stb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++)
            if (stb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational winner pick: highest priority among candidates, ties to lowest index.
module irq_prio_sel
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0]             cand,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
    output logic                           valid,
    output logic [ID_W-1:0]                id
);

    logic [PRIO_W-1:0] best;

    // Linear scan; strict '>' keeps the earliest index on equal priority
    always_comb begin
        valid = 1'b0;
        id    = '0;
        best  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand[i] && (!valid || prio[i] > best)) begin
                valid = 1'b1;
                id    = ID_W'(i);
                best  = prio[i];
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// APB-programmed interrupt arbiter: edge-latched pending bits, enable/priority/
// threshold filtering, claim/complete handshake and a registered CPU interrupt.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_SRC    = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0040
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  pready,
    output logic                  perr,
    input  logic [NUM_SRC-1:0]    irq_src,
    output logic                  cpu_interrupt
);

    localparam logic [ADDR_WIDTH-1:0] BASE_C = ADDR_WIDTH'(BASE_ADDR);

    logic [NUM_SRC-1:0]             pending_q, pending_d;
    logic [NUM_SRC-1:0]             enable_q, enable_d;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
    logic [PRIO_W-1:0]              thresh_q, thresh_d;
    logic                           busy_q, busy_d;
    logic [ID_W-1:0]                isvc_q, isvc_d;
    logic [NUM_SRC-1:0]             src_q, src_d;
    logic [DATA_WIDTH-1:0]          prdata_q, prdata_d;
    logic                           pready_q, pready_d;
    logic                           perr_q, perr_d;
    logic                           cpu_int_q, cpu_int_d;

    apb_acc_t           acc;
    logic [31:0]        wdata32, rdata32;
    logic [31:0]        en_m, pr_m, th_m;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] cand;
    logic               win_vld;
    logic [ID_W-1:0]    win_id;

    // Address/strobe bits that never reach a register
    logic unused_ok;
    assign unused_ok = ^{paddr[1:0], en_m[31:NUM_SRC], pr_m[31:PRIO_W*NUM_SRC], th_m[31:PRIO_W]};

    assign wdata32 = 32'(pdata);
    assign en_m    = byte_merge(32'(enable_q), wdata32, pstb);
    assign pr_m    = byte_merge(32'(prio_q), wdata32, pstb);
    assign th_m    = byte_merge(32'(thresh_q), wdata32, pstb);

    // Decode: an access is taken once, in the cycle pready is still low
    always_comb begin
        acc.fire = psel & penable & ~pready_q;
        acc.wr   = pwrite;
        acc.off  = paddr[4:2];
        acc.err  = (paddr[ADDR_WIDTH-1:5] != BASE_C[ADDR_WIDTH-1:5]) || (paddr[4:2] > OFF_CLAIM);
    end

    // A source is eligible only when pending, enabled and above threshold
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cand
        assign cand[i] = pending_q[i] & enable_q[i] & (prio_q[i] > thresh_q);
    end

    irq_prio_sel #(.NUM_SRC(NUM_SRC)) u_sel (
        .cand  (cand),
        .prio  (prio_q),
        .valid (win_vld),
        .id    (win_id)
    );

    // Register file, claim/complete and pending update
    always_comb begin
        enable_d  = enable_q;
        prio_d    = prio_q;
        thresh_d  = thresh_q;
        busy_d    = busy_q;
        isvc_d    = isvc_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        perr_d    = 1'b0;
        clr       = '0;
        rdata32   = '0;
        src_d     = irq_src;
        cpu_int_d = ~busy_q & win_vld;

        if (acc.fire) begin
            pready_d = 1'b1;
            perr_d   = acc.err;
            if (!acc.err) begin
                if (acc.wr) begin
                    case (acc.off)
                        OFF_PENDING: clr      = wdata32[NUM_SRC-1:0];
                        OFF_ENABLE:  enable_d = en_m[NUM_SRC-1:0];
                        OFF_PRIO:    prio_d   = pr_m[PRIO_W*NUM_SRC-1:0];
                        OFF_THRESH:  thresh_d = th_m[PRIO_W-1:0];
                        OFF_CLAIM:   if (busy_q && wdata32[3:0] == 4'(isvc_q) + 4'd1) busy_d = 1'b0;
                        default: ;
                    endcase
                end else begin
                    case (acc.off)
                        OFF_PENDING: rdata32 = 32'(pending_q);
                        OFF_ENABLE:  rdata32 = 32'(enable_q);
                        OFF_PRIO:    rdata32 = 32'(prio_q);
                        OFF_THRESH:  rdata32 = 32'(thresh_q);
                        OFF_CLAIM: begin
                            if (!busy_q && win_vld) begin
                                rdata32 = 32'(win_id) + 32'd1;
                                clr     = NUM_SRC'(1) << win_id;
                                busy_d  = 1'b1;
                                isvc_d  = win_id;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            prdata_d = DATA_WIDTH'(rdata32);
        end

        // A fresh rising edge beats any clear landing in the same cycle
        pending_d = (pending_q & ~clr) | (irq_src & ~src_q);
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pending_q <= '0;
            enable_q  <= '0;
            prio_q    <= '0;
            thresh_q  <= '0;
            busy_q    <= 1'b0;
            isvc_q    <= '0;
            src_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            perr_q    <= 1'b0;
            cpu_int_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            prio_q    <= prio_d;
            thresh_q  <= thresh_d;
            busy_q    <= busy_d;
            isvc_q    <= isvc_d;
            src_q     <= src_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            perr_q    <= perr_d;
            cpu_int_q <= cpu_int_d;
        end
    end

    assign prdata        = prdata_q;
    assign pready        = pready_q;
    assign perr          = perr_q;
    assign cpu_interrupt = cpu_int_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_irq_arbiter;

    localparam int          NS   = 8;
    localparam logic [31:0] BASE = 32'h2000_0040;

    logic        pclk = 1'b0;
    logic        presetn = 1'b1;
    logic [31:0] paddr = '0;
    logic [31:0] pdata = '0;
    logic [31:0] prdata;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]  pstb = 4'h0;
    logic        pready, perr;
    logic [NS-1:0] irq_src = '0;
    logic        cpu_interrupt;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    irq_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SRC(NS), .BASE_ADDR(BASE)) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pdata(pdata), .prdata(prdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pstb(pstb),
        .pready(pready), .perr(perr), .irq_src(irq_src), .cpu_interrupt(cpu_interrupt)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_pend[NS];
    bit       m_en[NS];
    bit [2:0] m_prio[NS];
    bit [2:0] m_thr;
    bit       m_busy;
    int       m_isvc;
    bit       m_prev[NS];
    bit       m_done, m_pready, m_perr, m_rd, m_cpu;
    logic [31:0] m_rdata;

    task automatic m_reset();
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = 0; m_en[i] = 0; m_prio[i] = 0; m_prev[i] = 0;
        end
        m_thr = 0; m_busy = 0; m_isvc = 0;
        m_done = 0; m_pready = 0; m_perr = 0; m_rd = 0; m_cpu = 0; m_rdata = 0;
    endtask

    // Highest priority eligible source, lowest index on ties; -1 if none
    function automatic int m_winner();
        int w = -1;
        int bp = 0;
        for (int i = 0; i < NS; i++)
            if (m_pend[i] && m_en[i] && m_prio[i] > m_thr && int'(m_prio[i]) > bp) begin
                w = i; bp = int'(m_prio[i]);
            end
        return w;
    endfunction

    task automatic m_step();
        int w;
        bit cpu_n;
        bit rise[NS];
        int off;
        w = m_winner();
        cpu_n = !m_busy && (w >= 0);
        for (int i = 0; i < NS; i++) begin
            rise[i] = irq_src[i] && !m_prev[i];
            m_prev[i] = irq_src[i];
        end
        m_pready = 0;
        if (psel && penable && !m_done) begin
            m_done = 1; m_pready = 1; m_rd = !pwrite; m_rdata = 0;
            off = int'(paddr[4:2]);
            m_perr = (paddr[31:5] != BASE[31:5]) || off > 4;
            if (!m_perr) begin
                if (pwrite) begin
                    case (off)
                        0: for (int i = 0; i < NS; i++) if (pdata[i]) m_pend[i] = 0;
                        1: if (pstb[0]) for (int i = 0; i < NS; i++) m_en[i] = pdata[i];
                        2: for (int i = 0; i < NS; i++)
                               for (int b = 0; b < 3; b++)
                                   if (pstb[(3*i+b)/8]) m_prio[i][b] = pdata[3*i+b];
                        3: if (pstb[0]) m_thr = pdata[2:0];
                        default: if (m_busy && int'(pdata[3:0]) == m_isvc + 1) m_busy = 0;
                    endcase
                end else begin
                    case (off)
                        0: for (int i = 0; i < NS; i++) m_rdata[i] = m_pend[i];
                        1: for (int i = 0; i < NS; i++) m_rdata[i] = m_en[i];
                        2: for (int i = 0; i < NS; i++) m_rdata = m_rdata | (32'(m_prio[i]) << (3*i));
                        3: m_rdata = 32'(m_thr);
                        default: if (!m_busy && w >= 0) begin
                            m_rdata = 32'(w + 1);
                            m_pend[w] = 0; m_busy = 1; m_isvc = w;
                        end
                    endcase
                end
            end
        end else if (!(psel && penable)) begin
            m_done = 0;
        end
        for (int i = 0; i < NS; i++) if (rise[i]) m_pend[i] = 1;
        m_cpu = cpu_n;
    endtask

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) m_reset();
        else m_step();
    end

    // Per-cycle comparison against the model
    always @(negedge pclk) begin
        if (checking) begin
            chk("cpu_interrupt", 32'(cpu_interrupt), 32'(m_cpu));
            chk("pready", 32'(pready), 32'(m_pready));
            if (m_pready) begin
                chk("perr", 32'(perr), 32'(m_perr));
                if (m_rd) chk("prdata", prdata, m_rdata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] stb, input int raise,
                       output logic [31:0] rd, output logic err);
        int n = 0;
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pdata = data; pstb = stb;
        @(posedge pclk); #1;
        penable = 1;
        if (raise >= 0) irq_src[raise] = 1'b1;
        do begin
            @(posedge pclk); #1; n++;
        end while (!pready && n < 8);
        if (!pready) begin
            checks++; errors++;
            $display("FAIL apb_timeout: got pready=0 expected 1 addr %0h", addr);
        end
        rd = prdata; err = perr;
        psel = 0; penable = 0;
    endtask

    task automatic wreg(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] r; logic e;
        apb(1, BASE + off, d, 4'hF, -1, r, e);
    endtask

    task automatic rreg(input logic [31:0] off, output logic [31:0] d);
        logic e;
        apb(0, BASE + off, 32'h0, 4'hF, -1, d, e);
    endtask

    task automatic do_reset();
        @(posedge pclk); #1;
        presetn = 0; psel = 0; penable = 0; irq_src = '0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d;
        logic e;

        do_reset();
        checking = 1;

        // Reset state
        chk("rst_cpu", 32'(cpu_interrupt), 0);
        chk("rst_pready", 32'(pready), 0);
        chk("rst_prdata", prdata, 0);
        rreg(32'h00, d); chk("rst_pending", d, 0);
        rreg(32'h04, d); chk("rst_enable", d, 0);
        rreg(32'h08, d); chk("rst_prio", d, 0);
        rreg(32'h0C, d); chk("rst_thresh", d, 0);
        rreg(32'h10, d); chk("rst_claim", d, 0);

        // Single source: latency, claim, deassert
        wreg(32'h04, 32'h01);
        wreg(32'h08, 32'h03);
        irq_src[0] = 1'b1;
        tick(1); chk("lat1_cpu", 32'(cpu_interrupt), 0);
        tick(1); chk("lat2_cpu", 32'(cpu_interrupt), 1);
        rreg(32'h10, d); chk("claim_src0", d, 1);
        tick(1); chk("after_claim_cpu", 32'(cpu_interrupt), 0);
        rreg(32'h00, d); chk("pend_after_claim", d, 0);
        wreg(32'h10, 32'h1);
        irq_src = '0;

        // Equal priority tie -> lowest index
        do_reset();
        wreg(32'h04, 32'h24);
        wreg(32'h08, 32'h0002_0100);
        irq_src = 8'h24;
        tick(2);
        rreg(32'h10, d); chk("tie_claim_a", d, 3);
        wreg(32'h10, 32'h3);
        rreg(32'h10, d); chk("tie_claim_b", d, 6);
        wreg(32'h10, 32'h6);
        irq_src = '0;

        // Threshold filtering
        do_reset();
        wreg(32'h0C, 32'h5);
        wreg(32'h04, 32'h02);
        wreg(32'h08, 32'h28);
        irq_src = 8'h02;
        tick(3); chk("thr_eq_cpu", 32'(cpu_interrupt), 0);
        rreg(32'h10, d); chk("thr_eq_claim", d, 0);
        wreg(32'h08, 32'h30);
        tick(2); chk("thr_gt_cpu", 32'(cpu_interrupt), 1);
        rreg(32'h10, d); chk("thr_gt_claim", d, 2);
        wreg(32'h10, 32'h2);
        irq_src = '0;

        // Complete mismatch ignored while busy
        do_reset();
        wreg(32'h04, 32'h14);
        wreg(32'h08, 32'h1080);
        irq_src = 8'h14;
        tick(2);
        rreg(32'h10, d); chk("busy_claim", d, 3);
        wreg(32'h10, 32'h4);
        rreg(32'h10, d); chk("busy_wrong_complete", d, 0);
        wreg(32'h10, 32'h3);
        tick(1); chk("complete_cpu", 32'(cpu_interrupt), 1);
        rreg(32'h10, d); chk("claim_after_complete", d, 5);
        wreg(32'h10, 32'h5);
        irq_src = '0;

        // Error decode: no side effects
        do_reset();
        wreg(32'h04, 32'hFF);
        apb(0, BASE + 32'h18, 32'h0, 4'hF, -1, d, e);
        chk("err18_perr", 32'(e), 1); chk("err18_data", d, 0);
        apb(1, BASE + 32'h1C, 32'h0, 4'hF, -1, d, e);
        chk("err1c_perr", 32'(e), 1);
        apb(1, BASE + 32'h24, 32'h0, 4'hF, -1, d, e);
        chk("errwin_perr", 32'(e), 1);
        rreg(32'h04, d); chk("err_no_effect", d, 32'hFF);

        // Reset in the middle of an access
        wreg(32'h08, 32'h00FF_FFFF);
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = BASE + 32'h04; pstb = 4'hF;
        @(posedge pclk); #1;
        penable = 1; presetn = 0;
        #1;
        chk("midrst_pready", 32'(pready), 0);
        chk("midrst_prdata", prdata, 0);
        chk("midrst_cpu", 32'(cpu_interrupt), 0);
        tick(2); chk("midrst_pready_hold", 32'(pready), 0);
        psel = 0; penable = 0; presetn = 1;
        rreg(32'h04, d); chk("midrst_enable", d, 0);
        rreg(32'h08, d); chk("midrst_prio", d, 0);

        // Edge beats same-cycle W1C
        do_reset();
        wreg(32'h04, 32'h01);
        wreg(32'h08, 32'h03);
        irq_src[0] = 1'b1; tick(1);
        irq_src[0] = 1'b0; tick(1);
        apb(1, BASE, 32'h1, 4'hF, 0, d, e);
        rreg(32'h00, d); chk("w1c_vs_edge", d, 1);
        wreg(32'h00, 32'h1);
        rreg(32'h00, d); chk("w1c_clears", d, 0);

        // Randomized traffic; the per-cycle compare does the checking
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int op;
            logic [31:0] a;
            irq_src = irq_src ^ NS'($urandom & $urandom & $urandom);
            op = $urandom_range(0, 9);
            case (op)
                0: apb(1, BASE + 32'h04, $urandom, 4'($urandom), -1, d, e);
                1: apb(1, BASE + 32'h08, $urandom, 4'($urandom), -1, d, e);
                2: apb(1, BASE + 32'h0C, 32'($urandom_range(0, 3)), 4'($urandom), -1, d, e);
                3: apb(1, BASE + 32'h00, $urandom, 4'hF, -1, d, e);
                4, 5: rreg(32'h10, d);
                6: begin
                    if (m_busy && $urandom_range(0, 9) < 7) wreg(32'h10, 32'(m_isvc + 1));
                    else wreg(32'h10, 32'($urandom_range(0, 15)));
                end
                7: begin
                    a = BASE + 32'(4 * $urandom_range(0, 7));
                    apb(0, a, 32'h0, 4'hF, -1, d, e);
                end
                8: begin
                    a = (($urandom_range(0, 1) == 1) ? BASE + 32'h20 : BASE - 32'h20) + 32'(4 * $urandom_range(0, 4));
                    apb($urandom_range(0, 1) == 1, a, $urandom, 4'hF, -1, d, e);
                end
                default: tick($urandom_range(1, 3));
            endcase
        end

        tick(2);
        checking = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
